// File: rtl/mgia_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : mgia_pixel_shifter
// Brief    : MGIA pixel serialiser; fetches display words and emits
//            1/2/4-bpp pixels MSB-first with optional 2x horizontal zoom.
// Revision : 1.0 - initial release
// ============================================================================
module mgia_pixel_shifter #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          CLK_I_25MHZ,
    input  logic          RST_I,
    input  logic          VREN_I,
    input  logic [1:0]    BPP_I,
    input  logic          ZOOM_I,
    output logic [AW-1:0] F_ADR_O,
    input  logic [DW-1:0] F_DAT_I,
    output logic [3:0]    PIX_O,
    output logic          PEN_O,
    output logic          OVF_O
);

    localparam int IW = $clog2(DW);

    localparam logic [1:0]    c_BPP_2     = 2'b01;
    localparam logic [1:0]    c_BPP_4     = 2'b10;
    localparam logic [IW-1:0] c_LAST_1BPP = IW'(DW - 1);
    localparam logic [IW-1:0] c_LAST_2BPP = IW'(DW / 2 - 1);
    localparam logic [IW-1:0] c_LAST_4BPP = IW'(DW / 4 - 1);

    logic          r_active;
    logic [DW-1:0] r_shift;
    logic [IW-1:0] r_idx;
    logic          r_hold;
    logic [1:0]    r_bpp;
    logic          r_zoom;
    logic [AW-1:0] r_adr;
    logic [3:0]    r_pix;
    logic          r_pen;
    logic          r_ovf;

    logic [3:0]    w_pix_top;
    logic [DW-1:0] w_shifted;
    logic [IW-1:0] w_last_idx;
    logic          w_hold_done;
    logic [AW-1:0] w_adr_next;
    logic          w_adr_wrap;

    // Mode-dependent pixel extraction, shift and last-pixel index (11 = 1bpp)
    always_comb begin
        w_pix_top  = {3'b000, r_shift[DW-1]};
        w_shifted  = {r_shift[DW-2:0], 1'b0};
        w_last_idx = c_LAST_1BPP;
        case (r_bpp)
            c_BPP_2: begin
                w_pix_top  = {2'b00, r_shift[DW-1:DW-2]};
                w_shifted  = {r_shift[DW-3:0], 2'b00};
                w_last_idx = c_LAST_2BPP;
            end
            c_BPP_4: begin
                w_pix_top  = r_shift[DW-1:DW-4];
                w_shifted  = {r_shift[DW-5:0], 4'b0000};
                w_last_idx = c_LAST_4BPP;
            end
            default: ;
        endcase
    end

    assign w_hold_done              = ~r_zoom | r_hold;
    assign {w_adr_wrap, w_adr_next} = {1'b0, r_adr} + {{AW{1'b0}}, 1'b1};

    always_ff @(posedge CLK_I_25MHZ or posedge RST_I) begin
        if (RST_I) begin
            r_active <= 1'b0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_hold   <= 1'b0;
            r_bpp    <= 2'b00;
            r_zoom   <= 1'b0;
            r_adr    <= '0;
            r_pix    <= 4'h0;
            r_pen    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_active <= VREN_I;
            // The pixel stage lags one cycle, so the final pixel still emerges on line end
            r_pix    <= r_active ? w_pix_top : 4'h0;
            r_pen    <= r_active ? (|w_pix_top) : 1'b0;

            if (!VREN_I) begin
                r_adr  <= '0;
                r_idx  <= '0;
                r_hold <= 1'b0;
            end else if (!r_active) begin
                r_shift <= F_DAT_I;
                r_adr   <= AW'(1);
                r_bpp   <= BPP_I;
                r_zoom  <= ZOOM_I;
                r_idx   <= '0;
                r_hold  <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_hold_done) begin
                r_hold <= 1'b0;
                if (r_idx == w_last_idx) begin
                    // Next word already valid on F_DAT_I: reload without a bubble
                    r_shift <= F_DAT_I;
                    r_adr   <= w_adr_next;
                    r_idx   <= '0;
                    if (w_adr_wrap) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_shift <= w_shifted;
                    r_idx   <= r_idx + IW'(1);
                end
            end else begin
                r_hold <= 1'b1;
            end
        end
    end

    assign F_ADR_O = r_adr;
    assign PIX_O   = r_pix;
    assign PEN_O   = r_pen;
    assign OVF_O   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mgia_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mgia_pixel_shifter
// Brief    : Scoreboard bench for mgia_pixel_shifter (DW=16, AW=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mgia_pixel_shifter;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          vren;
    logic [1:0]    bpp;
    logic          zoom;
    logic [AW-1:0] f_adr;
    logic [DW-1:0] f_dat;
    logic [3:0]    pix;
    logic          pen;
    logic          ovf;

    logic [DW-1:0] mem [4];

    typedef struct {
        logic [3:0]    pix;
        logic          pen;
        logic [AW-1:0] adr;
        logic          ovf;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    mgia_pixel_shifter #(.DW(DW), .AW(AW)) dut (
        .CLK_I_25MHZ (clk),
        .RST_I       (rst),
        .VREN_I      (vren),
        .BPP_I       (bpp),
        .ZOOM_I      (zoom),
        .F_ADR_O     (f_adr),
        .F_DAT_I     (f_dat),
        .PIX_O       (pix),
        .PEN_O       (pen),
        .OVF_O       (ovf)
    );

    // Address is registered by the DUT, so this is the 1-cycle synchronous read
    assign f_dat = mem[f_adr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pixel_of(input int c, input int b, input logic z);
        int          p;
        int          ppw;
        int          w;
        int          k;
        logic [15:0] wd;
        p   = z ? c / 2 : c;
        ppw = 16 / b;
        w   = p / ppw;
        k   = p % ppw;
        wd  = mem[w % 4];
        return 4'((32'(wd) >> (16 - (k + 1) * b)) & ((1 << b) - 1));
    endfunction

    function automatic logic ovf_of(input int e, input int l);
        return ((1 + e / l) >= 4);
    endfunction

    // One line of n enable cycles plus two trailing edges; edge 0 is line start
    task automatic run_line(input int n, input logic [1:0] m, input logic z,
                            input int chg_at, input logic [1:0] m_chg);
        int b;
        int l;
        b    = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        l    = (16 / b) * (z ? 2 : 1);
        bpp  = m;
        zoom = z;
        for (int e = 0; e <= n + 1; e++) begin
            exp_t x;
            exp_t y;
            vren = (e < n);
            if (e == chg_at) bpp = m_chg;
            if (e == 0) begin
                x.pix = 4'h0;
                x.adr = AW'(1);
            end else if (e <= n) begin
                x.pix = pixel_of(e - 1, b, z);
                x.adr = (e < n) ? AW'((1 + e / l) % 4) : '0;
            end else begin
                x.pix = 4'h0;
                x.adr = '0;
            end
            x.ovf = ovf_of((e < n) ? e : n - 1, l);
            x.pen = |x.pix;
            sb.push_back(x);
            @(posedge clk);
            #1;
            y = sb.pop_front();
            chk($sformatf("pix n=%0d e=%0d", n, e), 32'(pix), 32'(y.pix));
            chk($sformatf("pen n=%0d e=%0d", n, e), 32'(pen), 32'(y.pen));
            chk($sformatf("adr n=%0d e=%0d", n, e), 32'(f_adr), 32'(y.adr));
            chk($sformatf("ovf n=%0d e=%0d", n, e), 32'(ovf), 32'(y.ovf));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        vren = 1'b0;
        bpp  = 2'b00;
        zoom = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pix", 32'(pix), 32'h0);
        chk("reset pen", 32'(pen), 32'h0);
        chk("reset adr", 32'(f_adr), 32'h0);
        chk("reset ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        mem[0] = 16'h8001; mem[1] = 16'hFFFF; mem[2] = 16'h0000; mem[3] = 16'h0000;
        run_line(32, 2'b00, 1'b0, -1, 2'b00);

        mem[0] = 16'hE4E4; mem[1] = 16'h1B1B;
        run_line(16, 2'b01, 1'b0, -1, 2'b01);

        mem[0] = 16'h1234; mem[1] = 16'h5678;
        run_line(16, 2'b10, 1'b1, -1, 2'b10);

        mem[0] = 16'h8001; mem[1] = 16'hC3A5; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
        run_line(20, 2'b00, 1'b0, 5, 2'b10);
        run_line(8, 2'b10, 1'b0, -1, 2'b10);
        run_line(12, 2'b01, 1'b1, -1, 2'b01);

        mem[0] = 16'h8001; mem[1] = 16'hFFFF; mem[2] = 16'h5A5A; mem[3] = 16'h0F0F;
        run_line(80, 2'b00, 1'b0, -1, 2'b00);
        run_line(4, 2'b00, 1'b0, -1, 2'b00);

        // Asynchronous reset in the middle of word 2 of a 1bpp line
        mem[0] = 16'h8001; mem[1] = 16'hFFFF; mem[2] = 16'hFFFF; mem[3] = 16'hFFFF;
        bpp  = 2'b00;
        zoom = 1'b0;
        vren = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("pre-reset pix", 32'(pix), 32'h1);
        chk("pre-reset adr", 32'(f_adr), 32'h3);
        #3;
        rst = 1'b1;
        #1;
        chk("async reset pix", 32'(pix), 32'h0);
        chk("async reset pen", 32'(pen), 32'h0);
        chk("async reset adr", 32'(f_adr), 32'h0);
        chk("async reset ovf", 32'(ovf), 32'h0);
        vren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_line(18, 2'b00, 1'b0, -1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mgia_pixel_shifter.md
Name: mgia_pixel_shifter

Overview:
Parametrised video pixel serialiser for the MGIA display path. It fetches display words from a synchronous line/frame RAM by address, latches each word into a shift register, and emits pixels MSB-first at the dot clock. It supports 1/2/4 bits-per-pixel modes, optional 2x horizontal pixel doubling, and sticky address-overflow reporting. It sits between the MGIA timing generator (VREN_I) and the palette/DAC stage (PIX_O), and replaces the 1-bpp fixed-width shifter.

Parameters:
DW, 16, display word width in bits; power of two, 8..64.
AW, 6, fetch address width; F_ADR_O wraps modulo 2^AW.

Ports:
CLK_I_25MHZ  in   1   dot clock; all state is updated on its rising edge.
RST_I        in   1   asynchronous, active-high reset.
VREN_I       in   1   video read enable; high for the active part of a scanline.
BPP_I        in   2   pixel depth: 00=1bpp, 01=2bpp, 10=4bpp, 11=1bpp.
ZOOM_I       in   1   1 = hold each pixel for 2 dot clocks.
F_ADR_O      out  AW  fetch word address to RAM; registered.
F_DAT_I      in   DW  RAM read data for the address registered on the previous edge (1-cycle synchronous read).
PIX_O        out  4   current pixel value, zero-extended (a 1bpp pixel appears in bit 0).
PEN_O        out  1   OR of PIX_O; 1-bpp compatibility output.
OVF_O        out  1   sticky: address wrapped during the current line.

Behaviour:
- Reset (asynchronous, any time including mid-line): F_ADR_O=0, PIX_O=0, PEN_O=0, OVF_O=0, shift register=0, ACTIVE=0, dot/hold counters=0, latched mode=1bpp/no-zoom.
- ACTIVE is a register that holds VREN_I delayed by one clock.
- While idle, F_ADR_O=0, so F_DAT_I presents word 0.
- Line start: the first edge E0 with VREN_I=1 and ACTIVE=0 does the following:
  - shift register ← F_DAT_I (word 0);
  - F_ADR_O ← 1;
  - latch BPP_I and ZOOM_I (later changes are ignored until the next line);
  - pixel index ← 0, hold ← 0, OVF_O ← 0.
- Pixel output: on every edge with ACTIVE=1, PIX_O ← the top bpp bits of the shift register, zero-extended.
  - Pixel k of a word is bits [DW-1-k*bpp : DW-k*bpp-bpp].
  - Without zoom, PIX_O after edge E(k+1) = pixel k of the line.
  - With zoom, each pixel is visible for 2 consecutive cycles.
- Shifting: after the current pixel's hold completes (1 cycle, or 2 with zoom), the shift register shifts left by bpp and the pixel index increments.
- Word reload: on the edge that completes the hold of the last pixel (index PPW-1, where PPW=DW/bpp), and with VREN_I=1:
  - shift register ← F_DAT_I;
  - F_ADR_O ← F_ADR_O+1;
  - index ← 0.
  - The reload is seamless: no bubble between the last pixel of one word and the first of the next.
- Address wrap: when F_ADR_O increments from 2^AW-1 it wraps to 0 and OVF_O ← 1. OVF_O holds until the next line start or reset.
- Line end: on an edge with VREN_I=0:
  - F_ADR_O ← 0, index ← 0, hold ← 0, ACTIVE ← 0.
  - PIX_O still takes the current pixel if ACTIVE was 1; this emits the final pixel.
  - On the next edge PIX_O ← 0.
  - A line with VREN_I high for N cycles therefore yields exactly N pixel cycles, delayed by one cycle.
- VREN_I dropping mid-word abandons the rest of the word; the next line restarts at address 0.
- PEN_O is registered together with PIX_O and equals |PIX_O at all times.
- All counters use modulo arithmetic sized to their range: index is log2(DW) bits, hold is 1 bit.

Test Plan:
- Reset mid-line: assert RST_I while PIX_O=4'h1 and F_ADR_O=3 -> all outputs read 0 immediately, without waiting for a clock edge.
- 1bpp, no zoom, word0=16'h8001, word1=16'hFFFF, VREN_I high for 32 cycles:
  - PIX_O sequence is 1, 0×14, 1, then 16 ones, then 0;
  - F_ADR_O is 1 during word 0 and 2 during word 1;
  - PIX_O returns to 0 two edges after VREN_I falls.
- 2bpp, word0=16'hE4E4, 16 cycles: PIX_O = 3,2,1,0,3,2,1,0 followed by word1's pixels; reload occurs after 8 pixels.
- 4bpp with zoom, word0=16'h1234: PIX_O = 1,1,2,2,3,3,4,4; F_ADR_O increments only once per 8 cycles.
- Mode change mid-line: switch BPP_I from 00 to 10 after 5 cycles -> output stays 1bpp until VREN_I drops; the next line uses 4bpp.
- Wrap, AW=2, 1bpp, VREN_I high for 80 cycles -> F_ADR_O sequence 1,2,3,0,1; OVF_O rises on the edge where F_ADR_O goes 3→0 and clears at the next line start.
